// File: rtl/mips_pkg.sv
// Shared encodings and sizing helpers for the execute-stage multiply/divide unit.
package mips_pkg;

   typedef enum logic [1:0] {
      MD_MULT  = 2'b00,
      MD_MULTU = 2'b01,
      MD_DIV   = 2'b10,
      MD_DIVU  = 2'b11
   } mdOpT;

   typedef enum logic [1:0] {
      MD_IDLE = 2'b00,
      MD_CALC = 2'b01,
      MD_SIGN = 2'b10,
      MD_DONE = 2'b11
   } mdStateT;

   localparam int MD_DATA_WIDTH = 32;

   // One shift-add or restoring step per operand bit, so the last iteration index is width-1.
   function automatic int mdIterLast(input int width);
      return width - 1;
   endfunction

   function automatic int mdCountWidth(input int width);
      return $clog2(width);
   endfunction

endpackage

// File: rtl/mdu_cond_neg.sv
// Conditional two's-complement negate, used for operand magnitudes and result sign fixup.
module mdu_cond_neg #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] value,
   input  logic             enable,
   output logic [WIDTH-1:0] result
);

   assign result = enable ? (~value + WIDTH'(1)) : value;

endmodule

// File: rtl/mdu_iterative.sv
// Iterative MULT/MULTU/DIV/DIVU unit writing architectural HI/LO.
// Define MDU_DIV_EN to build the restoring divider; without it divides only time out like a real op.
module mdu_iterative
   import mips_pkg::*;
#(
   parameter int DATA_WIDTH = MD_DATA_WIDTH
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic [DATA_WIDTH-1:0] SrcA,
   input  logic [DATA_WIDTH-1:0] SrcB,
   input  logic [1:0]            MD_Op,
   input  logic                  Start,
   input  logic                  HI_Wr,
   input  logic                  LO_Wr,
   input  logic [DATA_WIDTH-1:0] WrData,
   output logic [DATA_WIDTH-1:0] HI,
   output logic [DATA_WIDTH-1:0] LO,
   output logic                  Busy,
   output logic                  Done,
   output logic                  DivZero
);

   localparam int W  = DATA_WIDTH;
   localparam int CW = mdCountWidth(DATA_WIDTH);
   localparam logic [CW-1:0] ITER_LAST = CW'(mdIterLast(DATA_WIDTH));

   mdStateT         state;
   logic [W-1:0]    opA;
   logic [W-1:0]    opB;
   logic [2*W-1:0]  acc;
   logic [CW-1:0]   count;
   logic            isDiv;
   logic            prodNeg;

   logic            signedOp;
   logic            signA;
   logic            signB;
   logic [W-1:0]    absA;
   logic [W-1:0]    absB;
   logic [W:0]      mulSum;
   logic [2*W-1:0]  prodFix;

   assign signedOp = (MD_Op == MD_MULT) || (MD_Op == MD_DIV);
   assign signA    = signedOp & SrcA[W-1];
   assign signB    = signedOp & SrcB[W-1];

   mdu_cond_neg #(.WIDTH(W)) uAbsA (.value(SrcA), .enable(signA), .result(absA));
   mdu_cond_neg #(.WIDTH(W)) uAbsB (.value(SrcB), .enable(signB), .result(absB));

   // Multiply keeps the multiplicand in opA and shifts the multiplier out of opB, LSB first.
   assign mulSum = {1'b0, acc[2*W-1:W]} + {1'b0, (opB[0] ? opA : {W{1'b0}})};

   mdu_cond_neg #(.WIDTH(2*W)) uFixProd (.value(acc), .enable(prodNeg), .result(prodFix));

`ifdef MDU_DIV_EN
   logic            remNeg;
   logic            divByZero;
   logic [W:0]      divShift;
   logic [W-1:0]    divTrial;
   logic            divOk;
   logic [W-1:0]    quoFix;
   logic [W-1:0]    remFix;

   // Divide shifts the dividend out of opA MSB first while quotient bits fill in behind it.
   // With a zero divisor every trial succeeds, leaving the dividend magnitude as the remainder.
   assign divShift = {acc[2*W-1:W], opA[W-1]};
   assign divOk    = (divShift >= {1'b0, opB});
   assign divTrial = divShift[W-1:0] - opB;

   mdu_cond_neg #(.WIDTH(W)) uFixQuo (.value(opA), .enable(prodNeg), .result(quoFix));
   mdu_cond_neg #(.WIDTH(W)) uFixRem (.value(acc[2*W-1:W]), .enable(remNeg), .result(remFix));
`endif

   // Control FSM and datapath; HI/LO only move on MTHI/MTLO in IDLE or at the SIGN edge.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state   <= MD_IDLE;
         opA     <= '0;
         opB     <= '0;
         acc     <= '0;
         count   <= '0;
         isDiv   <= 1'b0;
         prodNeg <= 1'b0;
         HI      <= '0;
         LO      <= '0;
         Busy    <= 1'b0;
         Done    <= 1'b0;
         DivZero <= 1'b0;
`ifdef MDU_DIV_EN
         remNeg    <= 1'b0;
         divByZero <= 1'b0;
`endif
      end else begin
         Done    <= 1'b0;
         DivZero <= 1'b0;
         unique case (state)
            MD_IDLE: begin
               if (Start) begin
                  opA     <= absA;
                  opB     <= absB;
                  acc     <= '0;
                  count   <= '0;
                  isDiv   <= MD_Op[1];
                  prodNeg <= signA ^ signB;
`ifdef MDU_DIV_EN
                  remNeg    <= signA;
                  divByZero <= (SrcB == '0);
`endif
                  Busy    <= 1'b1;
                  state   <= MD_CALC;
               end else begin
                  if (HI_Wr) HI <= WrData;
                  if (LO_Wr) LO <= WrData;
               end
            end
            MD_CALC: begin
               count <= count + CW'(1);
               if (!isDiv) begin
                  acc <= {mulSum, acc[W-1:1]};
                  opB <= opB >> 1;
               end
`ifdef MDU_DIV_EN
               else begin
                  acc[2*W-1:W] <= divOk ? divTrial : divShift[W-1:0];
                  opA          <= {opA[W-2:0], divOk};
               end
`endif
               if (count == ITER_LAST) state <= MD_SIGN;
            end
            MD_SIGN: begin
               if (!isDiv) begin
                  HI <= prodFix[2*W-1:W];
                  LO <= prodFix[W-1:0];
               end
`ifdef MDU_DIV_EN
               else begin
                  HI      <= remFix;
                  LO      <= divByZero ? {W{1'b1}} : quoFix;
                  DivZero <= divByZero;
               end
`endif
               Done  <= 1'b1;
               state <= MD_DONE;
            end
            MD_DONE: begin
               Busy  <= 1'b0;
               state <= MD_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mdu_iterative.sv
// Self-checking bench for mdu_iterative: vector table plus scoreboard, and hand sequences for
// MTHI/MTLO gating, Start-while-busy, mid-operation reset and the MDU_DIV_EN build option.
module tb_mdu_iterative;
   import mips_pkg::*;

   localparam int W   = 32;
   localparam int LAT = W + 2;

   logic          CLK = 1'b0;
   logic          RST = 1'b0;
   logic [W-1:0]  SrcA = '0;
   logic [W-1:0]  SrcB = '0;
   logic [1:0]    MD_Op = 2'b00;
   logic          Start = 1'b0;
   logic          HI_Wr = 1'b0;
   logic          LO_Wr = 1'b0;
   logic [W-1:0]  WrData = '0;
   logic [W-1:0]  HI;
   logic [W-1:0]  LO;
   logic          Busy;
   logic          Done;
   logic          DivZero;

   typedef struct {
      logic [W-1:0] hi;
      logic [W-1:0] lo;
      logic         dz;
      int           doneCyc;
   } expT;

   typedef struct {
      logic [1:0]   op;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] hi;
      logic [W-1:0] lo;
      logic         dz;
   } vecT;

   expT          sbQ[$];
   vecT          vecs[12];
   int           compared   = 0;
   int           mismatched = 0;
   int           cyc        = 0;
   int           busyRun    = 0;
   logic [W-1:0] modelHi    = '0;
   logic [W-1:0] modelLo    = '0;

   mdu_iterative #(.DATA_WIDTH(W)) dut (
      .CLK    (CLK),
      .RST    (RST),
      .SrcA   (SrcA),
      .SrcB   (SrcB),
      .MD_Op  (MD_Op),
      .Start  (Start),
      .HI_Wr  (HI_Wr),
      .LO_Wr  (LO_Wr),
      .WrData (WrData),
      .HI     (HI),
      .LO     (LO),
      .Busy   (Busy),
      .Done   (Done),
      .DivZero(DivZero)
   );

   always #5 CLK = ~CLK;

   task automatic checkValue(input string name, input logic [63:0] act, input logic [63:0] req);
      compared++;
      if (act !== req) begin
         mismatched++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (negedge %0d)", name, act, req, cyc);
      end
   endtask

   // Runs every negedge: tracks Busy length and retires scoreboard entries on Done.
   task automatic checkOutput();
      expT e;
      if (!RST) busyRun = 0;
      else if (Busy) busyRun++;
      else if (busyRun != 0) begin
         checkValue("busyCycles", 64'(busyRun), 64'(LAT));
         busyRun = 0;
      end
      if (Done) begin
         if (sbQ.size() == 0) checkValue("doneWithoutOp", 64'(Done), 64'(0));
         else begin
            e = sbQ.pop_front();
            checkValue("resultHi", 64'(HI), 64'(e.hi));
            checkValue("resultLo", 64'(LO), 64'(e.lo));
            checkValue("divZero", 64'(DivZero), 64'(e.dz));
            checkValue("doneLatency", 64'(cyc), 64'(e.doneCyc));
         end
      end else if (DivZero) begin
         checkValue("strayDivZero", 64'(DivZero), 64'(0));
      end
   endtask

   task automatic tick();
      @(negedge CLK);
      cyc++;
      checkOutput();
   endtask

   task automatic applyStimulus(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                input logic [W-1:0] hi, input logic [W-1:0] lo, input logic dz);
      expT e;
      MD_Op = op;
      SrcA  = a;
      SrcB  = b;
      Start = 1'b1;
      e.hi = hi;
      e.lo = lo;
      e.dz = dz;
      e.doneCyc = cyc + LAT;
      sbQ.push_back(e);
      modelHi = hi;
      modelLo = lo;
      tick();
      Start = 1'b0;
   endtask

   task automatic waitIdle();
      for (int i = 0; i < LAT + 20; i++) begin
         if (sbQ.size() == 0 && !Busy) return;
         tick();
      end
      checkValue("pendingResults", 64'(sbQ.size()), 64'(0));
      checkValue("busyTimeout", 64'(Busy), 64'(0));
      sbQ.delete();
   endtask

   task automatic writeHiLo(input logic [W-1:0] hi, input logic [W-1:0] lo);
      HI_Wr  = 1'b1;
      WrData = hi;
      tick();
      HI_Wr  = 1'b0;
      LO_Wr  = 1'b1;
      WrData = lo;
      tick();
      LO_Wr  = 1'b0;
      modelHi = hi;
      modelLo = lo;
   endtask

   initial begin
      logic [W-1:0] expHi;
      logic [W-1:0] expLo;
      logic         expDz;

      vecs[0]  = '{MD_MULT,  32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 1'b0};
      vecs[1]  = '{MD_MULTU, 32'hFFFF_FFFE, 32'h0000_0003, 32'h0000_0002, 32'hFFFF_FFFA, 1'b0};
      vecs[2]  = '{MD_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0};
      vecs[3]  = '{MD_DIVU,  32'd100,       32'd7,         32'd2,         32'd14,        1'b0};
      vecs[4]  = '{MD_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0};
      vecs[5]  = '{MD_DIVU,  32'h1234_5678, 32'h0000_0000, 32'h1234_5678, 32'hFFFF_FFFF, 1'b1};
      vecs[6]  = '{MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0};
      vecs[7]  = '{MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0};
      vecs[8]  = '{MD_MULT,  32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0};
      vecs[9]  = '{MD_DIV,   32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0};
      vecs[10] = '{MD_DIV,   32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 1'b1};
      vecs[11] = '{MD_DIVU,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0};

      repeat (2) tick();
      checkValue("resetHi", 64'(HI), 64'(0));
      checkValue("resetLo", 64'(LO), 64'(0));
      checkValue("resetBusy", 64'(Busy), 64'(0));
      checkValue("resetDone", 64'(Done), 64'(0));
      checkValue("resetDivZero", 64'(DivZero), 64'(0));
      RST = 1'b1;
      tick();

      for (int i = 0; i < 12; i++) begin
         expHi = vecs[i].hi;
         expLo = vecs[i].lo;
         expDz = vecs[i].dz;
`ifndef MDU_DIV_EN
         if (vecs[i].op[1]) begin
            expHi = modelHi;
            expLo = modelLo;
            expDz = 1'b0;
         end
`endif
         applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b, expHi, expLo, expDz);
         waitIdle();
      end

      HI_Wr  = 1'b1;
      WrData = 32'hA5A5_A5A5;
      tick();
      HI_Wr = 1'b0;
      checkValue("mthiIdle", 64'(HI), 64'h0000_0000_A5A5_A5A5);
      LO_Wr  = 1'b1;
      WrData = 32'h5A5A_5A5A;
      tick();
      LO_Wr = 1'b0;
      checkValue("mtloIdle", 64'(LO), 64'h0000_0000_5A5A_5A5A);

      HI_Wr  = 1'b1;
      WrData = 32'hDEAD_BEEF;
      applyStimulus(MD_MULTU, 32'd3, 32'd5, 32'd0, 32'd15, 1'b0);
      HI_Wr = 1'b0;
      checkValue("mthiWithStart", 64'(HI), 64'h0000_0000_A5A5_A5A5);
      repeat (3) tick();
      HI_Wr  = 1'b1;
      LO_Wr  = 1'b1;
      WrData = 32'hCAFE_F00D;
      tick();
      HI_Wr = 1'b0;
      LO_Wr = 1'b0;
      checkValue("mthiBusy", 64'(HI), 64'h0000_0000_A5A5_A5A5);
      checkValue("mtloBusy", 64'(LO), 64'h0000_0000_5A5A_5A5A);
      MD_Op = MD_MULTU;
      SrcA  = 32'd7;
      SrcB  = 32'd7;
      Start = 1'b1;
      tick();
      Start = 1'b0;
      waitIdle();
      repeat (LAT + 4) tick();

      writeHiLo(32'h2222_3333, 32'h4444_5555);
      applyStimulus(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
      repeat (9) tick();
      #2 RST = 1'b0;
      #1;
      checkValue("rstBusy", 64'(Busy), 64'(0));
      checkValue("rstDone", 64'(Done), 64'(0));
      checkValue("rstHi", 64'(HI), 64'(0));
      checkValue("rstLo", 64'(LO), 64'(0));
      sbQ.delete();
      modelHi = '0;
      modelLo = '0;
      tick();
      RST = 1'b1;
      tick();
      applyStimulus(MD_MULTU, 32'd3, 32'd5, 32'd0, 32'd15, 1'b0);
      waitIdle();

      writeHiLo(32'h1111_1111, 32'h1111_1111);
`ifdef MDU_DIV_EN
      applyStimulus(MD_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0);
`else
      applyStimulus(MD_DIVU, 32'd100, 32'd7, 32'h1111_1111, 32'h1111_1111, 1'b0);
`endif
      waitIdle();
      repeat (3) tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
